// File: rtl/spi_xfer_arbiter.sv
// Round-robin burst arbiter sharing one spi_ctrl exchange engine among NUM_REQ requesters.
// A grant owns chip select for len+1 bytes; each byte is a TX handshake, one exchange, an RX handshake.
module spi_xfer_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int REQ_IDX    = 2,
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 8,
   parameter int SS_WIDTH   = 2
) (
   input  logic                            clk_i,
   input  logic                            soft_rst_i,
   input  logic                            enable_i,
   input  logic [NUM_REQ-1:0]              req_i,
   input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len_i,
   input  logic [NUM_REQ*SS_WIDTH-1:0]     req_ss_i,
   output logic [NUM_REQ-1:0]              gnt_o,
   input  logic [NUM_REQ-1:0]              tx_valid_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   tx_data_i,
   output logic [NUM_REQ-1:0]              tx_ready_o,
   output logic [NUM_REQ-1:0]              rx_valid_o,
   output logic [DATA_WIDTH-1:0]           rx_data_o,
   input  logic [NUM_REQ-1:0]              rx_ready_i,
   output logic [NUM_REQ-1:0]              done_o,
   output logic                            abort_o,
   output logic                            cs_active_o,
   output logic [SS_WIDTH-1:0]             cs_sel_o,
   output logic                            eng_exchange_o,
   output logic [DATA_WIDTH-1:0]           eng_send_data_o,
   input  logic                            eng_busy_i,
   input  logic                            eng_ready_i,
   input  logic [DATA_WIDTH-1:0]           eng_recv_data_i
);

   typedef enum logic [2:0] {IDLE, WAIT_TX, LAUNCH, XFER, RX_PUSH, DONE} state_t;

   state_t                state_q, state_d;
   logic [REQ_IDX-1:0]    w_q, w_d, rr_last_q, rr_last_d;
   logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
   logic [SS_WIDTH-1:0]   cs_sel_q, cs_sel_d;
   logic                  exch_q, exch_d;
   logic [DATA_WIDTH-1:0] send_q, send_d, rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d, abort_q, abort_d;

   logic [LEN_WIDTH-1:0]  len_arr [NUM_REQ];
   logic [SS_WIDTH-1:0]   ss_arr  [NUM_REQ];
   logic [DATA_WIDTH-1:0] txd_arr [NUM_REQ];
   logic [NUM_REQ-1:0]    w_onehot;
   logic                  burst_active;
   logic                  win_found;
   logic [REQ_IDX-1:0]    win_idx, cand;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign len_arr[g] = req_len_i[g*LEN_WIDTH +: LEN_WIDTH];
      assign ss_arr[g]  = req_ss_i[g*SS_WIDTH +: SS_WIDTH];
      assign txd_arr[g] = tx_data_i[g*DATA_WIDTH +: DATA_WIDTH];
   end

   // Scan offsets from farthest to nearest so the nearest requester after rr_last wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         cand = REQ_IDX'((int'(rr_last_q) + i) % NUM_REQ);
         if (req_i[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign w_onehot     = NUM_REQ'(1) << w_q;
   assign burst_active = (state_q == WAIT_TX) || (state_q == LAUNCH) ||
                         (state_q == XFER)    || (state_q == RX_PUSH);

   always_comb begin
      state_d    = state_q;
      w_d        = w_q;
      rr_last_d  = rr_last_q;
      cnt_d      = cnt_q;
      cs_sel_d   = cs_sel_q;
      exch_d     = exch_q;
      send_d     = send_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      abort_d    = abort_q;
      tx_ready_o = '0;
      case (state_q)
         IDLE: begin
            abort_d = 1'b0;
            if (enable_i && win_found) begin
               w_d      = win_idx;
               cnt_d    = len_arr[win_idx];
               cs_sel_d = ss_arr[win_idx];
               state_d  = WAIT_TX;
            end
         end
         WAIT_TX: begin
            tx_ready_o = w_onehot & {NUM_REQ{~eng_busy_i}};
            // A byte offered in the same cycle the request drops still goes out.
            if (tx_valid_i[w_q] && !eng_busy_i) begin
               send_d  = txd_arr[w_q];
               exch_d  = 1'b1;
               state_d = LAUNCH;
            end else if (!req_i[w_q]) begin
               abort_d = 1'b1;
               state_d = DONE;
            end
         end
         LAUNCH: begin
            if (eng_busy_i) begin
               exch_d  = 1'b0;
               state_d = XFER;
            end
         end
         XFER: begin
            if (eng_ready_i) begin
               rx_data_d  = eng_recv_data_i;
               rx_valid_d = 1'b1;
               state_d    = RX_PUSH;
            end
         end
         RX_PUSH: begin
            if (rx_ready_i[w_q]) begin
               rx_valid_d = 1'b0;
               if (cnt_q == '0) begin
                  state_d = DONE;
               end else begin
                  cnt_d   = cnt_q - LEN_WIDTH'(1);
                  state_d = WAIT_TX;
               end
            end
         end
         DONE: begin
            rr_last_d = w_q;
            abort_d   = 1'b0;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (soft_rst_i) begin
         state_q    <= IDLE;
         w_q        <= '0;
         rr_last_q  <= REQ_IDX'(NUM_REQ - 1);
         cnt_q      <= '0;
         cs_sel_q   <= '0;
         exch_q     <= 1'b0;
         send_q     <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         w_q        <= w_d;
         rr_last_q  <= rr_last_d;
         cnt_q      <= cnt_d;
         cs_sel_q   <= cs_sel_d;
         exch_q     <= exch_d;
         send_q     <= send_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         abort_q    <= abort_d;
      end
   end

   assign gnt_o           = burst_active ? w_onehot : '0;
   assign cs_active_o     = burst_active;
   assign cs_sel_o        = cs_sel_q;
   assign done_o          = (state_q == DONE) ? w_onehot : '0;
   assign abort_o         = abort_q;
   assign rx_valid_o      = rx_valid_q ? w_onehot : '0;
   assign rx_data_o       = rx_data_q;
   assign eng_exchange_o  = exch_q;
   assign eng_send_data_o = send_q;

endmodule
